compare_pipe: RTL and testbench
===============================

COMPARE_PIPE -- requirements
Module: compare_pipe

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits; legal values 8..64, multiple of 4.
REQ-002 Parameter STAGES, default 2, pipeline depth in cycles; legal values 1..4.
REQ-003 Parameter TAG_W, default 5, width of the pass-through tag (e.g. destination register index).
REQ-004 Port clk_i, input, 1, single clock; all state updates on rising edge.
REQ-005 Port rst_ni, input, 1, reset, asynchronous and active-low.
REQ-006 Port flush_i, input, 1, synchronous pipeline flush.
REQ-007 Port in_valid_i, input, 1, input operands valid.
REQ-008 Port in_ready_o, output, 1, unit accepts input this cycle.
REQ-009 Port op_i, input, 4, operation: 0 EQ, 1 NE, 2 LT, 3 GE, 4 LTU, 5 GEU, 6 MIN, 7 MAX, 8 MINU, 9 MAXU; 10..15 illegal.
REQ-010 Port operand_a_i / operand_b_i, input, WIDTH each, operands.
REQ-011 Port tag_i, input, TAG_W, carried unchanged to tag_o.
REQ-012 Port out_valid_o, output, 1, result valid.
REQ-013 Port out_ready_i, input, 1, consumer accepts result.
REQ-014 Port result_o, output, 1, compare outcome flag.
REQ-015 Port value_o, output, WIDTH, selected operand for MIN/MAX ops, else {WIDTH-1 zeros, result_o}.
REQ-016 Port equal_o, output, 1, operand_a == operand_b, independent of op.
REQ-017 Port illegal_o, output, 1, op was illegal or compiled out.
REQ-018 Port tag_o, output, TAG_W, tag of the result.

Function
REQ-019 Transfer in: in_valid_i && in_ready_o at rising edge; transfer out: out_valid_o && out_ready_i.
REQ-020 Stall = out_valid_o && !out_ready_i; stall freezes every stage register, including valid bits.
REQ-021 in_ready_o = !stall && !flush_i; purely combinational, no dependence on in_valid_i.
REQ-022 Latency exactly STAGES cycles from input transfer to out_valid_o when never stalled; throughput one op per cycle.
REQ-023 Stage 1 computes per-4-bit-nibble less/greater/equal flags; remaining stages reduce them MSB-first by priority; with STAGES=1 all reduction happens before the single register.
REQ-024 Signed ops (LT, GE, MIN, MAX) compare two's complement; unsigned ops compare raw magnitude; -2^(WIDTH-1) and 2^(WIDTH-1)-1 handled without overflow (no negation of operands).
REQ-025 result_o: EQ a==b, NE a!=b, LT/LTU a<b, GE/GEU a>=b, MIN/MINU a<=b, MAX/MAXU a>=b.
REQ-026 value_o for MIN/MINU = smaller operand, MAX/MAXU = larger; on equality value_o = operand_a.
REQ-027 Illegal op: result_o=0, value_o=0, equal_o still valid, illegal_o=1; op still occupies a slot and produces out_valid_o.
REQ-028 flush_i=1 clears all stage valid bits at next edge, overriding stall; an input presented in the same cycle is not accepted.
REQ-029 Outputs other than out_valid_o are don't-care while out_valid_o=0 but shall hold stable while stalled.

Reset
REQ-030 rst_ni low clears all valid bits immediately (asynchronously); out_valid_o=0, result_o=0, value_o=0, equal_o=0, illegal_o=0, tag_o=0.
REQ-031 Reset asserted mid-operation discards all in-flight ops; first accept allowed on first edge after rst_ni rises.

Configuration
REQ-032 Macro COMPARE_PIPE_MINMAX_EN defined: ops 6..9 implemented per REQ-025/026.
REQ-033 Macro undefined: ops 6..9 treated as illegal per REQ-027; no value-mux logic synthesised; value_o = {zeros, result_o}.

Verification
REQ-034 WIDTH=32, STAGES=2, LT a=0xFFFFFFFF b=0x00000001 tag=3 -> after 2 cycles out_valid_o=1, result_o=1, equal_o=0, tag_o=3.
REQ-035 LTU same operands -> result_o=0; GEU -> result_o=1; EQ a=b=0x80000000 -> result_o=1, equal_o=1.
REQ-036 MINEN defined, MIN a=0x80000000 b=0x7FFFFFFF -> value_o=0x80000000, result_o=1; MAXU same -> value_o=0x80000000; macro undefined -> illegal_o=1, value_o=0.
REQ-037 Back-to-back 4 ops with out_ready_i held 0 for 3 cycles -> in_ready_o=0 while stalled, outputs stable, all 4 results delivered in order, none lost or duplicated.
REQ-038 flush_i asserted with 2 ops in flight and in_valid_i=1 -> no out_valid_o for those ops or the concurrent input; next op accepted the following cycle emerges after STAGES cycles.
REQ-039 rst_ni pulsed low mid-stream -> out_valid_o drops without a clock edge; op 15 -> illegal_o=1, result_o=0.

Source files
------------

// File: rtl/compare_pipe.sv
// compare_pipe: pipelined integer comparator with optional MIN/MAX selection.
//
// Stage 1 forms per-nibble less/greater flags; the following stage reduces
// them MSB-first and decodes the operation; any further stages are plain
// delay registers. With STAGES=1 all of it sits in front of a single register.
// Every stage (valid bits included) freezes while the output is stalled.
//
// Build option: define COMPARE_PIPE_MINMAX_EN to implement MIN/MAX/MINU/MAXU
// (ops 6..9). Without it those ops are reported as illegal and value_o is
// just the zero-extended result flag.
//
// Ports:
//   clk_i, rst_ni (async active-low), flush_i (sync pipeline clear)
//   in_valid_i / in_ready_o      : input handshake
//   op_i, operand_a_i, operand_b_i, tag_i : operation, operands, pass-through tag
//   out_valid_o / out_ready_i    : output handshake
//   result_o, value_o, equal_o, illegal_o, tag_o : registered results
module compare_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] operand_a_i,
    input  logic [WIDTH-1:0] operand_b_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             result_o,
    output logic [WIDTH-1:0] value_o,
    output logic             equal_o,
    output logic             illegal_o,
    output logic [TAG_W-1:0] tag_o
);
    localparam int NIB = WIDTH / 4;
    localparam int PD  = (STAGES > 1) ? STAGES - 1 : 1;

    localparam logic [3:0] OP_EQ   = 4'd0;
    localparam logic [3:0] OP_NE   = 4'd1;
    localparam logic [3:0] OP_LT   = 4'd2;
    localparam logic [3:0] OP_GE   = 4'd3;
    localparam logic [3:0] OP_LTU  = 4'd4;
    localparam logic [3:0] OP_GEU  = 4'd5;
    localparam logic [3:0] OP_MIN  = 4'd6;
    localparam logic [3:0] OP_MAX  = 4'd7;
    localparam logic [3:0] OP_MINU = 4'd8;
    localparam logic [3:0] OP_MAXU = 4'd9;

    logic w_stall;
    logic w_fire_in;

    assign w_stall    = out_valid_o && !out_ready_i;
    assign in_ready_o = !w_stall && !flush_i;
    assign w_fire_in  = in_valid_i && in_ready_o;

    // Per-nibble flags straight from the operands.
    logic [NIB-1:0] w_nlt;
    logic [NIB-1:0] w_ngt;
    logic           w_slt;
    logic           w_sgt;
    logic [3:0]     w_top_a;
    logic [3:0]     w_top_b;

    for (genvar g = 0; g < NIB; g++) begin : g_nib
        assign w_nlt[g] = operand_a_i[4*g +: 4] < operand_b_i[4*g +: 4];
        assign w_ngt[g] = operand_a_i[4*g +: 4] > operand_b_i[4*g +: 4];
    end

    // Inverting the sign bit maps two's complement order onto unsigned order,
    // so the signed compare never needs to negate an operand.
    assign w_top_a = {~operand_a_i[WIDTH-1], operand_a_i[WIDTH-2:WIDTH-4]};
    assign w_top_b = {~operand_b_i[WIDTH-1], operand_b_i[WIDTH-2:WIDTH-4]};
    assign w_slt   = w_top_a < w_top_b;
    assign w_sgt   = w_top_a > w_top_b;

    // Inputs to the reduction/decode logic (registered or direct).
    logic             w_r_valid;
    logic [3:0]       w_r_op;
    logic [NIB-1:0]   w_r_nlt;
    logic [NIB-1:0]   w_r_ngt;
    logic             w_r_slt;
    logic             w_r_sgt;
    logic [TAG_W-1:0] w_r_tag;
`ifdef COMPARE_PIPE_MINMAX_EN
    logic [WIDTH-1:0] w_r_a;
    logic [WIDTH-1:0] w_r_b;
`endif

    if (STAGES == 1) begin : g_s1_comb
        assign w_r_valid = w_fire_in;
        assign w_r_op    = op_i;
        assign w_r_nlt   = w_nlt;
        assign w_r_ngt   = w_ngt;
        assign w_r_slt   = w_slt;
        assign w_r_sgt   = w_sgt;
        assign w_r_tag   = tag_i;
`ifdef COMPARE_PIPE_MINMAX_EN
        assign w_r_a     = operand_a_i;
        assign w_r_b     = operand_b_i;
`endif
    end else begin : g_s1_reg
        logic             r_s1_valid;
        logic [3:0]       r_s1_op;
        logic [NIB-1:0]   r_s1_nlt;
        logic [NIB-1:0]   r_s1_ngt;
        logic             r_s1_slt;
        logic             r_s1_sgt;
        logic [TAG_W-1:0] r_s1_tag;
`ifdef COMPARE_PIPE_MINMAX_EN
        logic [WIDTH-1:0] r_s1_a;
        logic [WIDTH-1:0] r_s1_b;
`endif

        // Stage 1 register: nibble flags plus the fields later stages need.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_s1_valid <= 1'b0;
                r_s1_op    <= 4'd0;
                r_s1_nlt   <= '0;
                r_s1_ngt   <= '0;
                r_s1_slt   <= 1'b0;
                r_s1_sgt   <= 1'b0;
                r_s1_tag   <= '0;
`ifdef COMPARE_PIPE_MINMAX_EN
                r_s1_a     <= '0;
                r_s1_b     <= '0;
`endif
            end else if (flush_i) begin
                r_s1_valid <= 1'b0;
            end else if (!w_stall) begin
                r_s1_valid <= w_fire_in;
                r_s1_op    <= op_i;
                r_s1_nlt   <= w_nlt;
                r_s1_ngt   <= w_ngt;
                r_s1_slt   <= w_slt;
                r_s1_sgt   <= w_sgt;
                r_s1_tag   <= tag_i;
`ifdef COMPARE_PIPE_MINMAX_EN
                r_s1_a     <= operand_a_i;
                r_s1_b     <= operand_b_i;
`endif
            end
        end

        assign w_r_valid = r_s1_valid;
        assign w_r_op    = r_s1_op;
        assign w_r_nlt   = r_s1_nlt;
        assign w_r_ngt   = r_s1_ngt;
        assign w_r_slt   = r_s1_slt;
        assign w_r_sgt   = r_s1_sgt;
        assign w_r_tag   = r_s1_tag;
`ifdef COMPARE_PIPE_MINMAX_EN
        assign w_r_a     = r_s1_a;
        assign w_r_b     = r_s1_b;
`endif
    end

    // MSB-first priority chain over the lower nibbles: a higher differing
    // nibble overrides whatever the lower ones decided.
    logic [NIB-2:0] w_clt;
    logic [NIB-2:0] w_cgt;
    assign w_clt[0] = w_r_nlt[0];
    assign w_cgt[0] = w_r_ngt[0];
    for (genvar g = 1; g < NIB - 1; g++) begin : g_chain
        assign w_clt[g] = w_r_nlt[g] | (!w_r_ngt[g] & w_clt[g-1]);
        assign w_cgt[g] = w_r_ngt[g] | (!w_r_nlt[g] & w_cgt[g-1]);
    end

    logic w_lt_u;
    logic w_gt_u;
    logic w_lt_s;
    logic w_eq;
    assign w_lt_u = w_r_nlt[NIB-1] | (!w_r_ngt[NIB-1] & w_clt[NIB-2]);
    assign w_gt_u = w_r_ngt[NIB-1] | (!w_r_nlt[NIB-1] & w_cgt[NIB-2]);
    assign w_lt_s = w_r_slt | (!w_r_sgt & w_clt[NIB-2]);
    assign w_eq   = !w_lt_u && !w_gt_u;
`ifdef COMPARE_PIPE_MINMAX_EN
    logic w_gt_s;
    logic w_mm;
    assign w_gt_s = w_r_sgt | (!w_r_slt & w_cgt[NIB-2]);
`endif

    logic             w_res;
    logic             w_ill;
    logic [WIDTH-1:0] w_val;

    // Operation decode into the result flag and the illegal indication.
    always_comb begin
        w_res = 1'b0;
        w_ill = 1'b0;
`ifdef COMPARE_PIPE_MINMAX_EN
        w_mm  = 1'b0;
`endif
        case (w_r_op)
            OP_EQ:   w_res = w_eq;
            OP_NE:   w_res = !w_eq;
            OP_LT:   w_res = w_lt_s;
            OP_GE:   w_res = !w_lt_s;
            OP_LTU:  w_res = w_lt_u;
            OP_GEU:  w_res = !w_lt_u;
`ifdef COMPARE_PIPE_MINMAX_EN
            OP_MIN:  begin w_res = !w_gt_s; w_mm = 1'b1; end
            OP_MAX:  begin w_res = !w_lt_s; w_mm = 1'b1; end
            OP_MINU: begin w_res = !w_gt_u; w_mm = 1'b1; end
            OP_MAXU: begin w_res = !w_lt_u; w_mm = 1'b1; end
`endif
            default: begin w_res = 1'b0; w_ill = 1'b1; end
        endcase
    end

`ifdef COMPARE_PIPE_MINMAX_EN
    // For MIN ops res means a<=b, for MAX ops a>=b: either way res picks a,
    // which also makes equality return operand_a.
    always_comb begin
        if (w_mm) begin
            w_val = w_res ? w_r_a : w_r_b;
        end else begin
            w_val = {{(WIDTH-1){1'b0}}, w_res};
        end
    end
`else
    assign w_val = {{(WIDTH-1){1'b0}}, w_res};
`endif

    // Result stages; the last one drives the outputs directly.
    logic [PD-1:0]            r_pv;
    logic [PD-1:0]            r_pres;
    logic [PD-1:0]            r_peq;
    logic [PD-1:0]            r_pill;
    logic [PD-1:0][WIDTH-1:0] r_pval;
    logic [PD-1:0][TAG_W-1:0] r_ptag;

    // First result stage, loaded from the decode logic.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pv[0]   <= 1'b0;
            r_pres[0] <= 1'b0;
            r_peq[0]  <= 1'b0;
            r_pill[0] <= 1'b0;
            r_pval[0] <= '0;
            r_ptag[0] <= '0;
        end else if (flush_i) begin
            r_pv[0]   <= 1'b0;
        end else if (!w_stall) begin
            r_pv[0]   <= w_r_valid;
            r_pres[0] <= w_res;
            r_peq[0]  <= w_eq;
            r_pill[0] <= w_ill;
            r_pval[0] <= w_val;
            r_ptag[0] <= w_r_tag;
        end
    end

    for (genvar k = 1; k < PD; k++) begin : g_delay
        // Extra delay stage for deeper pipelines.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_pv[k]   <= 1'b0;
                r_pres[k] <= 1'b0;
                r_peq[k]  <= 1'b0;
                r_pill[k] <= 1'b0;
                r_pval[k] <= '0;
                r_ptag[k] <= '0;
            end else if (flush_i) begin
                r_pv[k]   <= 1'b0;
            end else if (!w_stall) begin
                r_pv[k]   <= r_pv[k-1];
                r_pres[k] <= r_pres[k-1];
                r_peq[k]  <= r_peq[k-1];
                r_pill[k] <= r_pill[k-1];
                r_pval[k] <= r_pval[k-1];
                r_ptag[k] <= r_ptag[k-1];
            end
        end
    end

    assign out_valid_o = r_pv[PD-1];
    assign result_o    = r_pres[PD-1];
    assign equal_o     = r_peq[PD-1];
    assign illegal_o   = r_pill[PD-1];
    assign value_o     = r_pval[PD-1];
    assign tag_o       = r_ptag[PD-1];

endmodule

// File: tb/tb_compare_pipe.sv
// Scoreboard bench for compare_pipe (WIDTH=32, STAGES=2, TAG_W=5).
module tb_compare_pipe;
    localparam int WIDTH  = 32;
    localparam int STAGES = 2;
    localparam int TAG_W  = 5;
`ifdef COMPARE_PIPE_MINMAX_EN
    localparam bit MM_EN = 1'b1;
`else
    localparam bit MM_EN = 1'b0;
`endif

    typedef struct {
        logic [3:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [TAG_W-1:0] tag;
        logic             res;
        logic [WIDTH-1:0] val;
        logic             eq;
        logic             ill;
    } vec_t;

    typedef struct {
        logic             res;
        logic [WIDTH-1:0] val;
        logic             eq;
        logic             ill;
        logic [TAG_W-1:0] tag;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [TAG_W-1:0] tag;
    logic             out_valid;
    logic             out_ready;
    logic             result;
    logic [WIDTH-1:0] value;
    logic             equal;
    logic             illegal;
    logic [TAG_W-1:0] tag_out;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q[$];
    vec_t tbl[20];

    compare_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .op_i(op), .operand_a_i(opa), .operand_b_i(opb), .tag_i(tag),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .result_o(result), .value_o(value), .equal_o(equal),
        .illegal_o(illegal), .tag_o(tag_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Expected response; min/max ops become illegal when compiled out.
    function automatic exp_t exp_of(input vec_t v);
        exp_t e;
        e.res = v.res; e.val = v.val; e.eq = v.eq; e.ill = v.ill; e.tag = v.tag;
        if (!MM_EN && v.op >= 4'd6 && v.op <= 4'd9) begin
            e.res = 1'b0; e.val = '0; e.ill = 1'b1;
        end
        return e;
    endfunction

    // Present one op and hold it until accepted (bounded).
    task automatic send(input vec_t v, output int tries);
        bit acc;
        acc = 1'b0; tries = 0;
        op = v.op; opa = v.a; opb = v.b; tag = v.tag; in_valid = 1'b1;
        while (!acc && tries < 50) begin
            @(negedge clk);
            acc = in_ready;
            tries++;
            @(posedge clk);
        end
        if (acc) q.push_back(exp_of(v));
        else chk("send_timeout", 64'd0, 64'd1);
        #1 in_valid = 1'b0;
    endtask

    // Send into an empty pipe and check out_valid appears exactly STAGES cycles later.
    task automatic send_lat(input vec_t v, output int tries);
        send(v, tries);
        for (int k = 1; k <= STAGES; k++) begin
            if (k > 1) @(posedge clk);
            @(negedge clk);
            chk($sformatf("latency_c%0d", k), 64'(out_valid), (k == STAGES) ? 64'd1 : 64'd0);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: check the head of the scoreboard whenever a result is shown
    // (every stalled cycle too), pop it on transfer.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_out_valid", 64'd1, 64'd0);
            end else begin
                e = q[0];
                chk($sformatf("tag"), 64'(tag_out), 64'(e.tag));
                chk($sformatf("result_t%0d", e.tag), 64'(result), 64'(e.res));
                chk($sformatf("value_t%0d", e.tag), 64'(value), 64'(e.val));
                chk($sformatf("equal_t%0d", e.tag), 64'(equal), 64'(e.eq));
                chk($sformatf("illegal_t%0d", e.tag), 64'(illegal), 64'(e.ill));
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        //            op     a             b             tag    res   val           eq    ill
        tbl[0]  = '{4'd2,  32'hFFFFFFFF, 32'h00000001, 5'd3,  1'b1, 32'h00000001, 1'b0, 1'b0};
        tbl[1]  = '{4'd4,  32'hFFFFFFFF, 32'h00000001, 5'd4,  1'b0, 32'h00000000, 1'b0, 1'b0};
        tbl[2]  = '{4'd5,  32'hFFFFFFFF, 32'h00000001, 5'd5,  1'b1, 32'h00000001, 1'b0, 1'b0};
        tbl[3]  = '{4'd0,  32'h80000000, 32'h80000000, 5'd6,  1'b1, 32'h00000001, 1'b1, 1'b0};
        tbl[4]  = '{4'd1,  32'h12345678, 32'h12345678, 5'd7,  1'b0, 32'h00000000, 1'b1, 1'b0};
        tbl[5]  = '{4'd3,  32'h80000000, 32'h7FFFFFFF, 5'd8,  1'b0, 32'h00000000, 1'b0, 1'b0};
        tbl[6]  = '{4'd2,  32'h7FFFFFFF, 32'h80000000, 5'd9,  1'b0, 32'h00000000, 1'b0, 1'b0};
        tbl[7]  = '{4'd3,  32'h00000005, 32'h00000005, 5'd10, 1'b1, 32'h00000001, 1'b1, 1'b0};
        tbl[8]  = '{4'd4,  32'h0000F000, 32'h00010000, 5'd11, 1'b1, 32'h00000001, 1'b0, 1'b0};
        tbl[9]  = '{4'd6,  32'h80000000, 32'h7FFFFFFF, 5'd12, 1'b1, 32'h80000000, 1'b0, 1'b0};
        tbl[10] = '{4'd9,  32'h80000000, 32'h7FFFFFFF, 5'd13, 1'b1, 32'h80000000, 1'b0, 1'b0};
        tbl[11] = '{4'd7,  32'h00000003, 32'h00000003, 5'd14, 1'b1, 32'h00000003, 1'b1, 1'b0};
        tbl[12] = '{4'd8,  32'h00000010, 32'h00000020, 5'd15, 1'b1, 32'h00000010, 1'b0, 1'b0};
        tbl[13] = '{4'd8,  32'hFFFF0000, 32'h0000FFFF, 5'd16, 1'b0, 32'h0000FFFF, 1'b0, 1'b0};
        tbl[14] = '{4'd15, 32'h00000001, 32'h00000002, 5'd17, 1'b0, 32'h00000000, 1'b0, 1'b1};
        tbl[15] = '{4'd10, 32'h00000007, 32'h00000007, 5'd18, 1'b0, 32'h00000000, 1'b1, 1'b1};
        tbl[16] = '{4'd6,  32'hFFFFFFFF, 32'h00000001, 5'd19, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0};
        tbl[17] = '{4'd7,  32'hFFFFFFFF, 32'h00000001, 5'd20, 1'b0, 32'h00000001, 1'b0, 1'b0};
        tbl[18] = '{4'd4,  32'hFFFFFFF0, 32'hFFFFFFFF, 5'd21, 1'b1, 32'h00000001, 1'b0, 1'b0};
        tbl[19] = '{4'd3,  32'h00000010, 32'h0000000F, 5'd22, 1'b1, 32'h00000001, 1'b0, 1'b0};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = 4'd0; opa = '0; opb = '0; tag = '0;
        #3;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result",    64'(result),    64'd0);
        chk("rst_value",     64'(value),     64'd0);
        chk("rst_equal",     64'(equal),     64'd0);
        chk("rst_illegal",   64'(illegal),   64'd0);
        chk("rst_tag",       64'(tag_out),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Latency of a lone op into an idle pipe.
        send_lat(tbl[0], t);

        // Back-to-back stream through the whole table.
        for (int i = 1; i < 20; i++) send(tbl[i], t);
        repeat (STAGES + 3) @(posedge clk);
        #1;

        // Output stall for 3 cycles under a back-to-back burst of 4.
        fork
            begin
                int t1;
                for (int i = 1; i <= 4; i++) send(tbl[i], t1);
            end
            begin
                int w;
                w = 0;
                do begin
                    @(posedge clk);
                    #1;
                    w++;
                end while (!out_valid && w < 20);
                chk("stall_out_valid_seen", 64'(out_valid), 64'd1);
                out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_in_ready", 64'(in_ready), 64'd0);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        repeat (STAGES + 6) @(posedge clk);
        #1;

        // Flush with two ops in flight and a concurrent input.
        out_ready = 1'b0;
        send(tbl[5], t);
        send(tbl[6], t);
        op = tbl[7].op; opa = tbl[7].a; opb = tbl[7].b; tag = tbl[7].tag;
        in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        q.delete();
        #1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("flush_no_out_valid", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        send_lat(tbl[8], t);

        // Asynchronous reset in the middle of traffic.
        out_ready = 1'b0;
        send(tbl[9], t);
        send(tbl[10], t);
        chk("pre_reset_out_valid", 64'(out_valid), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 64'(out_valid), 64'd0);
        chk("async_rst_result",    64'(result),    64'd0);
        chk("async_rst_value",     64'(value),     64'd0);
        chk("async_rst_equal",     64'(equal),     64'd0);
        chk("async_rst_illegal",   64'(illegal),   64'd0);
        chk("async_rst_tag",       64'(tag_out),   64'd0);
        q.delete();
        rst_n = 1'b1;
        out_ready = 1'b1;
        send_lat(tbl[14], t);
        chk("first_edge_accept", 64'(t), 64'd1);
        send_lat(tbl[15], t);

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
